dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two masters: port 0 is the pipelined core's data port, port 1 is a secondary master (debug loader / DMA).
- Port 0 has fixed priority. A bounded-wait counter guarantees port 1 service.
- The block drives the RAM's MemWrite/MemRead/address/write_data and steers read data back with a one-cycle-latency valid.
- It raises a stall to the core whenever the core's access is denied.

Parameters:
- ADDR_W, 10, word address width (matches RAM address).
- DATA_W, 32, data width.
- MAX_WAIT, 4, max consecutive denied cycles for port 1 before it is forced to win. 0 means port 1 has strict priority.
- CNT_W, 16, width of the saturating contention counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 (core) request.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 granted this cycle.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  DATA_W  port 0 read data.
- stall0  out  1  core stall = req0 & ~gnt0.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same definitions for port 1.
- mem_we  out  1  RAM MemWrite.
- mem_re  out  1  RAM MemRead.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write_data.
- mem_rdata  in  DATA_W  RAM read_data, valid the cycle after mem_re.
- conflict_cnt  out  CNT_W  cycles in which both ports requested, saturating.

Behaviour:
- Reset (RST=1, async): wait_cnt=0, rd_pending=0, rd_owner=0, conflict_cnt=0. While RST is high, gnt0=gnt1=mem_we=mem_re=rvalid0=rvalid1=stall0=0, and mem_addr/mem_wdata=0.
- Grant is combinational in the request cycle, computed from req0/req1 and registered wait_cnt:
  - force1 = req1 & (wait_cnt >= MAX_WAIT).
  - gnt1 = req1 & (~req0 | force1).
  - gnt0 = req0 & ~gnt1.
- The winner's we/addr/wdata are muxed to the RAM.
  - mem_we = winner & we. mem_re = winner & ~we.
  - With no requester, mem_we=mem_re=0 and addr/wdata hold 0.
- A write commits at the CLK edge ending the grant cycle. The requester sees gnt and may drop or change its request on the next cycle.
- A read in grant cycle N sets rd_pending=1 and rd_owner=winner. In cycle N+1:
  - rvalid_owner=1 and rdata_owner=mem_rdata.
  - The non-owner's rvalid=0 and its rdata holds 0.
  - Back-to-back reads give rvalid every cycle.
- Requesters hold req/we/addr/wdata stable until gnt. Behaviour on change before gnt is undefined.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - Increments when req1 & ~gnt1.
  - Clears to 0 on gnt1 or when req1=0.
  - Never exceeds MAX_WAIT.
- Starvation bound: port 1 is granted at the latest MAX_WAIT+1 cycles after first asserting req1 under continuous req0.
- conflict_cnt increments on every cycle with req0 & req1. It saturates at 2^CNT_W-1 and never wraps.
- Simultaneous read by owner X in cycle N and grant to Y in cycle N+1: rvalid goes to X, and Y's access proceeds independently. No bubble.
- Reset asserted mid-read: the pending rvalid is discarded (never asserted after reset release). The first grant is possible in the cycle RST deasserts.
- The core treats stall0 as a pipeline freeze of the MEM stage. The arbiter does not buffer requests.

Test Plan:
- Reset: RST=1 with req0=req1=1 -> all gnt/mem_we/mem_re/rvalid=0, conflict_cnt=0. Release -> gnt0=1 in the same cycle.
- Port 0 only: write 0xDEADBEEF to addr 0x010, then read 0x010 -> gnt0 both cycles, mem_we=1 then mem_re=1. rvalid0=1 with rdata0=0xDEADBEEF the cycle after the read. stall0 always 0.
- Contention, MAX_WAIT=4: req0 held continuously with reads of 0x000..; req1 writes 0x55 to 0x3FF from cycle 0 -> gnt0 in cycles 0-3 and stall0=0. wait_cnt 1,2,3,4. gnt1 and stall0=1 in cycle 4, then gnt0 in cycle 5. conflict_cnt=5. RAM[0x3FF]=0x55.
- Interleaved reads: port 0 reads 0x001 in cycle N, port 1 reads 0x002 in cycle N+1 -> rvalid0 in N+1 only, rvalid1 in N+2 only, and the data matches RAM contents.
- MAX_WAIT=0 build: both request a read -> gnt1=1, gnt0=0, stall0=1 every cycle port 1 requests.
- Reset mid-read: grant a port 0 read, assert RST before the next edge -> rvalid0 stays 0 through and after release. Saturation: force conflict_cnt near 0xFFFF with 3 more conflict cycles -> the counter holds 0xFFFF.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data RAM: the core (port 0) has fixed priority and
// a bounded-wait counter forces a grant to the secondary master (port 1).
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              stall0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [WaitW-1:0] wait_q, wait_d;
  logic             rd_pending_q, rd_pending_d;
  logic             rd_owner_q, rd_owner_d;
  logic [CNT_W-1:0] conflict_q, conflict_d;
  logic             force1;

  // Grants are masked by RST so nothing reaches the RAM while reset is held.
  always_comb begin
    force1 = req1 && (wait_q >= WaitMax);
    gnt1   = ~RST & req1 & (~req0 | force1);
    gnt0   = ~RST & req0 & ~gnt1;
    stall0 = ~RST & req0 & ~gnt0;

    mem_we    = (gnt0 & we0) | (gnt1 & we1);
    mem_re    = (gnt0 & ~we0) | (gnt1 & ~we1);
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end else if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end

    rd_pending_d = mem_re;
    rd_owner_d   = mem_re ? gnt1 : rd_owner_q;

    wait_d = wait_q;
    if (!req1 || gnt1) begin
      wait_d = '0;
    end else if (wait_q < WaitMax) begin
      wait_d = wait_q + WaitW'(1);
    end

    conflict_d = conflict_q;
    if (req0 && req1 && (conflict_q != CntMax)) begin
      conflict_d = conflict_q + CNT_W'(1);
    end

    rvalid0 = rd_pending_q & ~rd_owner_q;
    rvalid1 = rd_pending_q & rd_owner_q;
    rdata0  = rvalid0 ? mem_rdata : '0;
    rdata1  = rvalid1 ? mem_rdata : '0;

    conflict_cnt = conflict_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_q       <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
      conflict_q   <= '0;
    end else begin
      wait_q       <= wait_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      conflict_q   <= conflict_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a behavioural RAM, plus a MAX_WAIT=0 /
// narrow-counter instance for strict port 1 priority and counter saturation.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  always #5 CLK = ~CLK;

  logic        req0, we0, req1, we1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, rvalid0, stall0, gnt1, rvalid1, mem_we, mem_re;
  logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
  logic [15:0] conflict_cnt;
  logic [31:0] ram [1024];

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(4), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .stall0(stall0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // RAM model: known pattern loaded while in reset, one-cycle read latency.
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h1000_0000 + 32'(i);
      mem_rdata <= '0;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
    end
  end

  logic        b_req0, b_we0, b_req1, b_we1;
  logic [9:0]  b_addr0, b_addr1;
  logic [31:0] b_wdata0, b_wdata1;
  logic        b_gnt0, b_rvalid0, b_stall0, b_gnt1, b_rvalid1, b_mem_we, b_mem_re;
  logic [31:0] b_rdata0, b_rdata1, b_mem_wdata;
  logic [31:0] b_mem_rdata = 32'hCAFE_F00D;
  logic [9:0]  b_mem_addr;
  logic [2:0]  b_conflict_cnt;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(0), .CNT_W(3)) dut_b (
    .CLK(CLK), .RST(RST),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
    .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0), .stall0(b_stall0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
    .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
    .mem_we(b_mem_we), .mem_re(b_mem_re), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .conflict_cnt(b_conflict_cnt)
  );

  typedef struct {
    logic        r0, w0;
    logic [9:0]  a0;
    logic [31:0] d0;
    logic        r1, w1;
    logic [9:0]  a1;
    logic [31:0] d1;
    logic        g0, g1, st, mwe, mre;
    logic [9:0]  maddr;
    logic [31:0] mwd;
    logic        rv0, rv1;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vecs [14];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    // r0 w0 a0 d0 | r1 w1 a1 d1 | g0 g1 st mwe mre maddr mwd | rv0 rv1 rd0 rd1
    vecs[0]  = '{1, 1, 10'h010, 32'hDEADBEEF, 0, 0, 10'h000, 32'h0,
                 1, 0, 0, 1, 0, 10'h010, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0};
    vecs[1]  = '{1, 0, 10'h010, 32'h0, 0, 0, 10'h000, 32'h0,
                 1, 0, 0, 0, 1, 10'h010, 32'h0, 0, 0, 32'h0, 32'h0};
    vecs[2]  = '{0, 0, 10'h000, 32'h0, 0, 0, 10'h000, 32'h0,
                 0, 0, 0, 0, 0, 10'h000, 32'h0, 1, 0, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1, 0, 10'h000, 32'h0, 1, 1, 10'h3FF, 32'h55,
                 1, 0, 0, 0, 1, 10'h000, 32'h0, 0, 0, 32'h0, 32'h0};
    vecs[4]  = '{1, 0, 10'h001, 32'h0, 1, 1, 10'h3FF, 32'h55,
                 1, 0, 0, 0, 1, 10'h001, 32'h0, 1, 0, 32'h1000_0000, 32'h0};
    vecs[5]  = '{1, 0, 10'h002, 32'h0, 1, 1, 10'h3FF, 32'h55,
                 1, 0, 0, 0, 1, 10'h002, 32'h0, 1, 0, 32'h1000_0001, 32'h0};
    vecs[6]  = '{1, 0, 10'h003, 32'h0, 1, 1, 10'h3FF, 32'h55,
                 1, 0, 0, 0, 1, 10'h003, 32'h0, 1, 0, 32'h1000_0002, 32'h0};
    vecs[7]  = '{1, 0, 10'h004, 32'h0, 1, 1, 10'h3FF, 32'h55,
                 0, 1, 1, 1, 0, 10'h3FF, 32'h55, 1, 0, 32'h1000_0003, 32'h0};
    vecs[8]  = '{1, 0, 10'h004, 32'h0, 0, 0, 10'h000, 32'h0,
                 1, 0, 0, 0, 1, 10'h004, 32'h0, 0, 0, 32'h0, 32'h0};
    vecs[9]  = '{0, 0, 10'h000, 32'h0, 0, 0, 10'h000, 32'h0,
                 0, 0, 0, 0, 0, 10'h000, 32'h0, 1, 0, 32'h1000_0004, 32'h0};
    vecs[10] = '{1, 0, 10'h001, 32'h0, 0, 0, 10'h000, 32'h0,
                 1, 0, 0, 0, 1, 10'h001, 32'h0, 0, 0, 32'h0, 32'h0};
    vecs[11] = '{0, 0, 10'h000, 32'h0, 1, 0, 10'h002, 32'h0,
                 0, 1, 0, 0, 1, 10'h002, 32'h0, 1, 0, 32'h1000_0001, 32'h0};
    vecs[12] = '{0, 0, 10'h000, 32'h0, 1, 0, 10'h3FF, 32'h0,
                 0, 1, 0, 0, 1, 10'h3FF, 32'h0, 0, 1, 32'h0, 32'h1000_0002};
    vecs[13] = '{0, 0, 10'h000, 32'h0, 0, 0, 10'h000, 32'h0,
                 0, 0, 0, 0, 0, 10'h000, 32'h0, 0, 1, 32'h0, 32'h55};

    {req0, we0, req1, we1} = '0;
    {addr0, addr1, wdata0, wdata1} = '0;
    {b_req0, b_we0, b_req1, b_we1} = '0;
    {b_addr0, b_addr1, b_wdata0, b_wdata1} = '0;

    // Reset with both ports requesting: everything stays quiet.
    repeat (3) @(posedge CLK);
    #1;
    req0 = 1'b1;
    req1 = 1'b1;
    @(negedge CLK);
    chk("rst.gnt0", gnt0, 0);
    chk("rst.gnt1", gnt1, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.mem_re", mem_re, 0);
    chk("rst.stall0", stall0, 0);
    chk("rst.rvalid", {rvalid0, rvalid1}, 0);
    chk("rst.conflict", conflict_cnt, 0);
    #1 RST = 1'b0;
    #1;
    chk("rel.gnt0", gnt0, 1);
    chk("rel.gnt1", gnt1, 0);
    req0 = 1'b0;
    req1 = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(posedge CLK);
      #1;
      req0 = vecs[i].r0; we0 = vecs[i].w0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
      req1 = vecs[i].r1; we1 = vecs[i].w1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
      @(negedge CLK);
      chk($sformatf("v%0d.gnt0", i), gnt0, vecs[i].g0);
      chk($sformatf("v%0d.gnt1", i), gnt1, vecs[i].g1);
      chk($sformatf("v%0d.stall0", i), stall0, vecs[i].st);
      chk($sformatf("v%0d.mem_we", i), mem_we, vecs[i].mwe);
      chk($sformatf("v%0d.mem_re", i), mem_re, vecs[i].mre);
      chk($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].maddr);
      chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].mwd);
      chk($sformatf("v%0d.rvalid0", i), rvalid0, vecs[i].rv0);
      chk($sformatf("v%0d.rvalid1", i), rvalid1, vecs[i].rv1);
      chk($sformatf("v%0d.rdata0", i), rdata0, vecs[i].rd0);
      chk($sformatf("v%0d.rdata1", i), rdata1, vecs[i].rd1);
    end
    chk("conflict_cnt", conflict_cnt, 5);
    chk("ram_3ff", ram[10'h3FF], 32'h55);

    // Reset lands between a granted read and its data cycle.
    @(posedge CLK);
    #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h010;
    @(negedge CLK);
    chk("mid.gnt0", gnt0, 1);
    #1;
    RST  = 1'b1;
    req0 = 1'b0;
    @(negedge CLK);
    chk("mid.rvalid0_rst", rvalid0, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk($sformatf("mid.rvalid0_post%0d", k), rvalid0, 0);
    end
    chk("mid.conflict", conflict_cnt, 0);

    // Strict port 1 priority and 3-bit counter saturation.
    @(posedge CLK);
    #1;
    b_req0 = 1'b1; b_addr0 = 10'h001;
    b_req1 = 1'b1; b_addr1 = 10'h002;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      chk($sformatf("b%0d.gnt1", k), b_gnt1, 1);
      chk($sformatf("b%0d.gnt0", k), b_gnt0, 0);
      chk($sformatf("b%0d.stall0", k), b_stall0, 1);
      chk($sformatf("b%0d.mem_addr", k), b_mem_addr, 10'h002);
      chk($sformatf("b%0d.rvalid1", k), b_rvalid1, (k > 0) ? 1 : 0);
      chk($sformatf("b%0d.rdata1", k), b_rdata1, (k > 0) ? 32'hCAFE_F00D : 32'h0);
      chk($sformatf("b%0d.conflict", k), b_conflict_cnt, (k > 7) ? 7 : k);
      @(posedge CLK);
      #1;
    end
    b_req0 = 1'b0;
    b_req1 = 1'b0;
    @(negedge CLK);
    chk("b.conflict_sat", b_conflict_cnt, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
